// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with csa4 cell)
// Brief    : Multi-cycle WIDTH-bit adder, one 4-bit nibble per clock, LSB first.
// Revision : 1.0
// ============================================================================

module csa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;

    // Upper pair is computed for both possible carries and selected by the lower carry.
    assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign w_hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

    assign sum  = {(w_lo[2] ? w_hi1[1:0] : w_hi0[1:0]), w_lo[1:0]};
    assign cout = w_lo[2] ? w_hi1[2] : w_hi0[2];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_cell_sum;
    logic             w_cell_cout;

    assign w_accept = (state_q == S_IDLE) && in_valid_i && in_ready_q;
    assign w_last   = (cnt_q == LAST_NIB);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept)    state_d = S_RUN;
            S_RUN:   if (w_last)      state_d = S_DONE;
            S_DONE:  if (out_ready_i) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
    end

    // Registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d == S_IDLE);
        end
    end

    assign in_ready_o = in_ready_q;

    // ---------------- Datapath ----------------
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                w_a_nib = a_q[4*k +: 4];
                w_b_nib = b_q[4*k +: 4];
            end
        end
    end

    csa4 u_cell (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (carry_q),
        .sum  (w_cell_sum),
        .cout (w_cell_cout)
    );

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (w_accept) begin
            a_d     = a_i;
            b_d     = b_i;
            carry_d = cin_i;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_q == CW'(k)) begin
                    sum_d[4*k +: 4] = w_cell_sum;
                end
            end
            carry_d = w_cell_cout;
            if (w_last) begin
                cout_d = w_cell_cout;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Scoreboard bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
// Revision : 1.0
// ============================================================================
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] res;
        int          acc;
    } exp_t;

    // ---------------- WIDTH=16 instance ----------------
    logic        rst_n, in_valid, out_ready, cin;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;
    exp_t        q16[$];
    bit          seen16 = 0;
    int          or_mode16 = 0;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum_o(sum), .cout_o(cout), .busy_o(busy)
    );

    // ---------------- WIDTH=4 instance ----------------
    logic        rst4_n, in_valid4, out_ready4, cin4;
    logic [3:0]  a4, b4;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [3:0]  sum4;
    exp_t        q4[$];
    bit          seen4 = 0;
    bit          done4 = 0;

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .a_i(a4), .b_i(b4), .cin_i(cin4), .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .sum_o(sum4), .cout_o(cout4), .busy_o(busy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        int n = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept16", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            @(posedge clk);
            #1;
            q16.push_back('{res: {1'b0, ta} + {1'b0, tb_} + {16'd0, tc}, acc: cyc});
        end
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        int n = 0;
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; in_valid4 = 1'b1;
        while (!in_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept4", {31'd0, in_ready4}, 32'd1);
        if (in_ready4) begin
            @(posedge clk);
            #1;
            q4.push_back('{res: {13'd0, {1'b0, ta} + {1'b0, tb_} + {4'd0, tc}}, acc: cyc});
        end
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain16", q16.size(), 32'd0);
    endtask

    // ---------------- monitors ----------------
    initial forever begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid16 actual sum=%0h cout=%0b required no result", sum, cout);
            end else begin
                if (!seen16) begin
                    chk("latency16", cyc - q16[0].acc, 32'd4);
                    seen16 = 1;
                end
                chk("sum16", {16'd0, sum}, {16'd0, q16[0].res[15:0]});
                chk("cout16", {31'd0, cout}, {31'd0, q16[0].res[16]});
                chk("in_ready_done16", {31'd0, in_ready}, 32'd0);
                if (out_ready) begin
                    void'(q16.pop_front());
                    seen16 = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (out_valid4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid4 actual sum=%0h cout=%0b required no result", sum4, cout4);
            end else begin
                if (!seen4) begin
                    chk("latency4", cyc - q4[0].acc, 32'd1);
                    seen4 = 1;
                end
                chk("sum4", {28'd0, sum4}, {28'd0, q4[0].res[3:0]});
                chk("cout4", {31'd0, cout4}, {31'd0, q4[0].res[4]});
                chk("busy_done4", {31'd0, busy4}, 32'd1);
                if (out_ready4) begin
                    void'(q4.pop_front());
                    seen4 = 0;
                end
            end
        end
    end

    // Downstream ready: mode 0 always ready, mode 1 random stalls, mode 2 driven by the sequence.
    initial forever begin
        @(posedge clk);
        #1;
        if (or_mode16 == 0)      out_ready = 1'b1;
        else if (or_mode16 == 1) out_ready = ($urandom % 3) != 0;
        out_ready4 = ($urandom % 3) != 0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- WIDTH=4 sequence ----------------
    initial begin
        int n;
        rst4_n = 1'b0; in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst4_n = 1'b1;
        for (int i = 0; i < 20; i++) op4(4'($urandom), 4'($urandom), 1'($urandom));
        n = 0;
        while (q4.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain4", q4.size(), 32'd0);
        done4 = 1;
    end

    // ---------------- WIDTH=16 sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Full carry ripple, then carry-in usage.
        op16(16'hFFFF, 16'h0001, 1'b0);
        drain16();
        op16(16'h1234, 16'h4321, 1'b1);
        drain16();

        // Busy-ignore: second set is presented during RUN and must wait for IDLE.
        op16(16'h0F0F, 16'h00F1, 1'b0);
        op16(16'hAAAA, 16'h5555, 1'b0);
        drain16();

        // Backpressure: hold DONE for 5 cycles.
        or_mode16 = 2;
        @(posedge clk);
        #1 out_ready = 1'b0;
        op16(16'h8000, 16'h8000, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        or_mode16 = 0;
        drain16();

        // Reset asserted at the edge that would write nibble 2.
        @(negedge clk);
        a = 16'h7777; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_sum", {16'd0, sum}, 32'd0);
        chk("rst_mid_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        op16(16'h0001, 16'h0001, 1'b0);
        drain16();

        // Random operands with random downstream stalls.
        or_mode16 = 1;
        for (int i = 0; i < 20; i++) op16(16'($urandom), 16'($urandom), 1'($urandom));
        drain16();

        n = 0;
        while (!done4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done4", {31'd0, done4}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
